// File: rtl/pueo_lowampa_pkg.sv
// Width helpers and the default beam map for the N-beam low-amplitude trigger.
package pueo_lowampa_pkg;

  localparam int MAPW       = 8;
  localparam int MAXMAPBITS = 2048;

  function automatic int sumWidth(input int nbits, input int nsum);
    return nbits + $clog2(nsum) + 1;
  endfunction

  function automatic int sqWidth(input int nbits, input int nsum);
    return 2 * sumWidth(nbits, nsum) - 2;
  endfunction

  function automatic int envWidth(input int nbits, input int nsum, input int nsamp, input int boxlen);
    return sqWidth(nbits, nsum) + $clog2(nsamp) + $clog2(boxlen / nsamp) + 1;
  endfunction

  // Beam b, slot j taps channel (b+j) % nchan; callers size-cast to their map width.
  function automatic logic [MAXMAPBITS-1:0] defaultMap(input int nbeams, input int nsum, input int nchan);
    logic [MAXMAPBITS-1:0] m;
    m = '0;
    for (int b = 0; b < nbeams; b++)
      for (int j = 0; j < nsum; j++)
        if ((b * nsum + j + 1) * MAPW <= MAXMAPBITS)
          m[(b * nsum + j) * MAPW +: MAPW] = MAPW'((b + j) % nchan);
    return m;
  endfunction

endpackage

// File: rtl/pueo_lowampa_beam_env.sv
// One beam: select/invert/sum (S1), square (S2), clock sum (S3), boxcar envelope (S4).
// Latency 4 clocks from data_i to envelope_o; free-running, no backpressure.
module pueo_lowampa_beam_env
  import pueo_lowampa_pkg::*;
#(
  parameter int NCHAN  = 8,
  parameter int NSAMP  = 4,
  parameter int NBITS  = 5,
  parameter int NSUM   = 5,
  parameter int BOXLEN = 8,
  parameter logic [NSUM*MAPW-1:0] MAP = (NSUM*MAPW)'(defaultMap(1, NSUM, NCHAN)),
  parameter logic [NSUM-1:0]      INV = '0
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  logic [NCHAN*NSAMP*NBITS-1:0]                    data_i,
  output logic [envWidth(NBITS, NSUM, NSAMP, BOXLEN)-1:0] envelope_o
);

  localparam int SUMW  = sumWidth(NBITS, NSUM);
  localparam int SQW   = sqWidth(NBITS, NSUM);
  localparam int CLKW  = SQW + $clog2(NSAMP);
  localparam int ENVW  = envWidth(NBITS, NSUM, NSAMP, BOXLEN);
  localparam int NHIST = BOXLEN / NSAMP - 1;
  localparam int HISTN = (NHIST > 0) ? NHIST : 1;

  if (BOXLEN % NSAMP != 0 || BOXLEN < NSAMP) begin : gBadBoxlen
    $error("BOXLEN must be a nonzero multiple of NSAMP");
  end

  logic signed [NBITS-1:0] sel [NSUM][NSAMP];

  for (genvar j = 0; j < NSUM; j++) begin : gSlot
    localparam int CH = int'(MAP[j*MAPW +: MAPW]);
    if (CH >= NCHAN) begin : gBadMap
      $error("BEAM_MAP entry exceeds NCHAN");
    end else begin : gTap
      for (genvar s = 0; s < NSAMP; s++) begin : gSamp
        assign sel[j][s] = data_i[NBITS*(NSAMP*CH+s) +: NBITS];
      end
    end
  end

  logic signed [SUMW-1:0] sumC  [NSAMP];
  logic        [SQW-1:0]  sqC   [NSAMP];
  logic signed [SUMW-1:0] s1Sum [NSAMP];
  logic        [SQW-1:0]  s2Sq  [NSAMP];
  logic        [CLKW-1:0] clkC;
  logic        [CLKW-1:0] s3Clk;
  logic        [CLKW-1:0] hist  [HISTN];
  logic        [ENVW-1:0] envC;

  // Negation happens after sign extension, so -2^(NBITS-1) inverts cleanly.
  always_comb begin
    for (int s = 0; s < NSAMP; s++) begin
      sumC[s] = '0;
      for (int j = 0; j < NSUM; j++) begin
        if (INV[j]) sumC[s] = sumC[s] - SUMW'(sel[j][s]);
        else        sumC[s] = sumC[s] + SUMW'(sel[j][s]);
      end
      sqC[s] = SQW'(s1Sum[s] * s1Sum[s]);
    end
    clkC = '0;
    for (int s = 0; s < NSAMP; s++) clkC = clkC + CLKW'(s2Sq[s]);
    envC = ENVW'(s3Clk);
    for (int k = 0; k < NHIST; k++) envC = envC + ENVW'(hist[k]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < NSAMP; s++) begin
        s1Sum[s] <= '0;
        s2Sq[s]  <= '0;
      end
      s3Clk <= '0;
      for (int k = 0; k < HISTN; k++) hist[k] <= '0;
      envelope_o <= '0;
    end else begin
      for (int s = 0; s < NSAMP; s++) begin
        s1Sum[s] <= sumC[s];
        s2Sq[s]  <= sqC[s];
      end
      s3Clk   <= clkC;
      hist[0] <= s3Clk;
      for (int k = 1; k < HISTN; k++) hist[k] <= hist[k-1];
      envelope_o <= envC;
    end
  end

endmodule

// File: rtl/pueo_lowampa_nbeam_trigger.sv
// N-beam low-amplitude trigger: per-beam envelopes vs double-buffered thresholds with holdoff.
// Latency 5 clocks data_i -> trigger_o (envelope_o at 4); free-running, no backpressure.
module pueo_lowampa_nbeam_trigger
  import pueo_lowampa_pkg::*;
#(
  parameter int NBEAMS  = 2,
  parameter int NCHAN   = 8,
  parameter int NSAMP   = 4,
  parameter int NBITS   = 5,
  parameter int NSUM    = 5,
  parameter int BOXLEN  = 8,
  parameter int HOLDOFF = 4,
  parameter logic [NBEAMS*NSUM*MAPW-1:0] BEAM_MAP = (NBEAMS*NSUM*MAPW)'(defaultMap(NBEAMS, NSUM, NCHAN)),
  parameter logic [NBEAMS*NSUM-1:0]      BEAM_INV = '0,
  localparam int ENVW  = envWidth(NBITS, NSUM, NSAMP, BOXLEN),
  localparam int ADDRW = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NCHAN*NSAMP*NBITS-1:0]  data_i,
  input  logic [ENVW-1:0]               thresh_i,
  input  logic [ADDRW-1:0]              thresh_addr_i,
  input  logic                          thresh_wr_i,
  input  logic                          thresh_update_i,
  output logic [NBEAMS-1:0]             trigger_o,
  output logic [NBEAMS*ENVW-1:0]        envelope_o
);

  localparam int HOLDW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic [ENVW-1:0]  env       [NBEAMS];
  logic [ENVW-1:0]  shadowThr [NBEAMS];
  logic [ENVW-1:0]  activeThr [NBEAMS];
  logic [HOLDW-1:0] holdCnt   [NBEAMS];

  for (genvar b = 0; b < NBEAMS; b++) begin : gBeam
    pueo_lowampa_beam_env #(
      .NCHAN  (NCHAN),
      .NSAMP  (NSAMP),
      .NBITS  (NBITS),
      .NSUM   (NSUM),
      .BOXLEN (BOXLEN),
      .MAP    (BEAM_MAP[b*NSUM*MAPW +: NSUM*MAPW]),
      .INV    (BEAM_INV[b*NSUM +: NSUM])
    ) uEnv (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .data_i     (data_i),
      .envelope_o (env[b])
    );
    assign envelope_o[b*ENVW +: ENVW] = env[b];
  end

  // Update reads the pre-write shadow, so a same-cycle write waits for the next update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < NBEAMS; b++) begin
        shadowThr[b] <= '1;
        activeThr[b] <= '1;
      end
    end else begin
      for (int b = 0; b < NBEAMS; b++) begin
        if (thresh_update_i) activeThr[b] <= shadowThr[b];
        if (thresh_wr_i && thresh_addr_i == ADDRW'(b)) shadowThr[b] <= thresh_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trigger_o <= '0;
      for (int b = 0; b < NBEAMS; b++) holdCnt[b] <= '0;
    end else begin
      for (int b = 0; b < NBEAMS; b++) begin
        if (env[b] > activeThr[b] && holdCnt[b] == '0) begin
          trigger_o[b] <= 1'b1;
          holdCnt[b]   <= HOLDW'(HOLDOFF);
        end else begin
          trigger_o[b] <= 1'b0;
          if (holdCnt[b] != '0) holdCnt[b] <= holdCnt[b] - HOLDW'(1);
        end
      end
    end
  end

endmodule
